top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter LOCK_CYCLES, default 32: number of clk_in1 rising edges after reset release before the output path is enabled (models clock-wizard lock time).
REQ-002 Parameter GLITCH_EN, default 0: 1 enables deterministic glitch injection on the sum capture register; 0 disables it.
REQ-003 Parameter GLITCH_PERIOD, default 16: cycle spacing of injected glitches when GLITCH_EN=1; legal range 2..256.
REQ-004 clk_in1  input  1  single system clock, all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-006 a  input  4  unsigned operand A.
REQ-007 b  input  4  unsigned operand B.
REQ-008 finout  output  5  registered unsigned sum a+b, bit 4 = carry.

Function
REQ-009 The block SHALL contain exactly one clock domain (clk_in1); no derived or gated clocks drive flops.
REQ-010 Lock counter: counts rising edges from reset release, saturates at LOCK_CYCLES; internal locked=1 once count reaches LOCK_CYCLES, stays 1 until next reset.
REQ-011 While locked=0, finout SHALL hold 5'b00000 regardless of a and b.
REQ-012 While locked=1, on each rising edge finout SHALL capture zero-extended a + zero-extended b (5-bit, no truncation, no overflow possible; max 15+15=30).
REQ-013 Latency: exactly 1 cycle; finout after edge N reflects a,b sampled at edge N; a, b held stable for one cycle produce a valid result.
REQ-014 The first capture occurs on the edge where locked transitions to 1 (edge LOCK_CYCLES after reset release).
REQ-015 Glitch counter: free-running modulo-GLITCH_PERIOD counter, starts at 0 when locked rises, increments every cycle while locked.
REQ-016 With GLITCH_EN=1, on the cycle where the glitch counter equals GLITCH_PERIOD-1, finout SHALL NOT update (holds previous value), modelling a missed capture; the next cycle captures normally.
REQ-017 With GLITCH_EN=0, the glitch counter SHALL have no effect on finout.
REQ-018 Input changes between edges SHALL have no effect on finout until the next rising edge (no combinational path a/b -> finout).

Reset
REQ-019 rst=0 SHALL immediately, without a clock edge, force finout=0, lock counter=0, locked=0, glitch counter=0.
REQ-020 Reset asserted mid-operation SHALL abort the current result; after release the full LOCK_CYCLES wait repeats before finout updates.
REQ-021 Reset release SHALL be sampled synchronously to clk_in1 (2-flop deassertion synchronizer) so lock counting starts cleanly; the synchronizer adds at most 2 cycles to the lock wait.

Verification
REQ-022 Reset: rst=0 for 5 ns, then 1; a=5,b=3 applied during first 20 cycles -> finout=0 throughout the lock window.
REQ-023 After lock (>=36 cycles post-release): a=5,b=3 -> finout=8 (01000) one edge later; a=15,b=1 -> 16 (10000); a=0,b=0 -> 0.
REQ-024 Back-to-back single-cycle vectors (10+5, 14+1, 7+12, 1+1, 8+8, 15+15, 4+2) -> finout 15, 15, 19, 2, 16, 30, 6 on consecutive edges, each one cycle after its inputs.
REQ-025 Async reset mid-stream: with finout=30, drive rst=0 between edges -> finout=0 before next edge; after release finout stays 0 for the lock window, then tracks a+b.
REQ-026 GLITCH_EN=1, GLITCH_PERIOD=4, inputs incrementing each cycle -> every 4th post-lock cycle finout repeats previous value; all other cycles equal a+b of prior edge.

Source files
------------

// File: rtl/top.sv
// rtl/top.sv - Registered 4-bit adder with lock-time gating and optional capture-glitch injection
module top #(
    parameter int LOCK_CYCLES   = 32,
    parameter int GLITCH_EN     = 0,
    parameter int GLITCH_PERIOD = 16
) (
    input  logic       clk_in1,
    input  logic       rst,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [4:0] finout
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int GW = (GLITCH_PERIOD > 1) ? $clog2(GLITCH_PERIOD) : 1;

    logic [1:0]    rst_sync;
    logic          rst_ok;
    logic [LW-1:0] lock_cnt;
    logic          locked;
    logic          capture;
    logic [GW-1:0] glitch_cnt;
    logic          glitch_wrap;
    logic          glitch_hit;

    // Reset asserts asynchronously but releases only after two clean clk_in1 edges.
    always_ff @(posedge clk_in1 or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_ok = rst_sync[1];

    always_ff @(posedge clk_in1 or negedge rst) begin
        if (!rst)                   lock_cnt <= '0;
        else if (rst_ok && !locked) lock_cnt <= lock_cnt + 1'b1;
    end

    assign locked  = (lock_cnt == LW'(LOCK_CYCLES));
    // Capture also on the edge where the counter reaches LOCK_CYCLES.
    assign capture = rst_ok && (locked || (lock_cnt == LW'(LOCK_CYCLES - 1)));

    assign glitch_wrap = (glitch_cnt == GW'(GLITCH_PERIOD - 1));
    assign glitch_hit  = (GLITCH_EN != 0) && glitch_wrap;

    always_ff @(posedge clk_in1 or negedge rst) begin
        if (!rst)         glitch_cnt <= '0;
        else if (capture) glitch_cnt <= glitch_wrap ? '0 : glitch_cnt + 1'b1;
    end

    always_ff @(posedge clk_in1 or negedge rst) begin
        if (!rst)                          finout <= 5'd0;
        else if (capture && !glitch_hit)   finout <= {1'b0, a} + {1'b0, b};
    end
endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - Self-checking bench for top: lock window, sums, async reset, glitch injection
module tb_top;
    localparam int L0 = 32;
    localparam int L1 = 8;
    localparam int P1 = 4;
    // The deassertion synchronizer delays the start of lock counting by two edges.
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a = 4'd5;
    logic [3:0] b = 4'd3;
    logic [4:0] fin0, fin1;

    int tests = 0;
    int fails = 0;

    bit released = 0;
    int edges = 0;
    logic [4:0] exp0 = 5'd0;
    logic [4:0] exp1 = 5'd0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [4:0] y;
    } vec_t;
    vec_t tbl[10];

    top #(.LOCK_CYCLES(L0)) dut0 (.clk_in1(clk), .rst(rst), .a(a), .b(b), .finout(fin0));
    top #(.LOCK_CYCLES(L1), .GLITCH_EN(1), .GLITCH_PERIOD(P1))
        dut1 (.clk_in1(clk), .rst(rst), .a(a), .b(b), .finout(fin1));

    initial begin
        #2;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: apply inputs, advance the reference model, compare both DUTs.
    task automatic step(input logic [3:0] aa, input logic [3:0] bb);
        int k0, k1;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
        if (released) begin
            edges++;
            k0 = edges - (L0 + SYNC);
            k1 = edges - (L1 + SYNC);
            if (k0 >= 0) exp0 = 5'(aa) + 5'(bb);
            if (k1 >= 0 && (k1 % P1) != P1 - 1) exp1 = 5'(aa) + 5'(bb);
        end
        chk("dut0_model", fin0, exp0);
        chk("dut1_model", fin1, exp1);
    endtask

    initial begin
        tbl[0] = '{4'd5,  4'd3,  5'd8};
        tbl[1] = '{4'd15, 4'd1,  5'd16};
        tbl[2] = '{4'd0,  4'd0,  5'd0};
        tbl[3] = '{4'd10, 4'd5,  5'd15};
        tbl[4] = '{4'd14, 4'd1,  5'd15};
        tbl[5] = '{4'd7,  4'd12, 5'd19};
        tbl[6] = '{4'd1,  4'd1,  5'd2};
        tbl[7] = '{4'd8,  4'd8,  5'd16};
        tbl[8] = '{4'd15, 4'd15, 5'd30};
        tbl[9] = '{4'd4,  4'd2,  5'd6};

        #1;
        chk("reset_dut0", fin0, 5'd0);
        chk("reset_dut1", fin1, 5'd0);
        #4;
        rst = 1'b1;
        released = 1;

        for (int i = 0; i < 20; i++) begin
            step(4'd5, 4'd3);
            chk("lock_window", fin0, 5'd0);
        end
        for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].a, tbl[i].b);
            chk("table", fin0, tbl[i].y);
        end

        // Inputs moving between edges must not reach the output.
        for (int i = 0; i < 4; i++) begin
            step(4'(i + 3), 4'(9 - i));
            a = ~a;
            b = b + 4'd7;
            #2;
            chk("no_comb_path", fin0, 5'(i + 3) + 5'(9 - i));
        end

        for (int i = 0; i < 200; i++) step(4'($urandom), 4'($urandom));

        step(4'd15, 4'd15);
        chk("pre_reset_30", fin0, 5'd30);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_dut0", fin0, 5'd0);
        chk("async_reset_dut1", fin1, 5'd0);
        released = 0;
        edges = 0;
        exp0 = 5'd0;
        exp1 = 5'd0;
        for (int i = 0; i < 3; i++) step(4'd9, 4'd9);
        #2;
        rst = 1'b1;
        released = 1;

        // Incrementing inputs expose every held (glitched) capture on dut1.
        for (int i = 0; i < 70; i++) step(4'(i), 4'(i >> 2));
        for (int i = 0; i < 100; i++) step(4'($urandom), 4'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
